dfa_monitor_param: RTL and testbench
====================================

Name: dfa_monitor_param

Overview:
- Parametrised next-generation instruction-flow monitor for one processor core.
- Walks a compressed DFA held in an external synchronous ROM, one step per executed instruction, indexed by the instruction's HASH_BITS-wide hash.
- On an illegal transition: pulses packet drop, runs the processor-reset acknowledge handshake, then re-arms at the root node.
- Adds over the previous generation: a programmable node-type table, overrun detection, an enable mode, saturating statistics counters and a config write acknowledge.

Parameters:
- HASH_BITS, 4: hash width. Valid vector width V = 2**HASH_BITS.
- NEXT_BITS, 12: next-state field width in a ROM word.
- TYPE_BITS, 4: node-type field width. Table depth = 2**TYPE_BITS.
- ADDR_BITS, 14: ROM address width.
- MULT_BITS, 3: per-type stride multiplier width.
- ROOT_ADDR, 0: ROM address of the DFA root node.
- CNT_BITS, 16: statistics counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- monitor_en  in  1  1 = check; 0 = never flag violations
- new_inst_signal  in  1  one instruction retired this cycle
- four_bit_hash  in  HASH_BITS  hash of that instruction
- inst_ready  out  1  monitor can accept new_inst_signal
- packet_done  in  1  end-of-packet pulse from the core
- processor_reset_seq  in  1  core reset sequence in progress
- packet_drop_signal  out  1  one-cycle violation pulse
- out_ack_reset  out  1  reset-acknowledge to the core
- mem_rd  out  1  ROM read strobe
- mem_addr  out  ADDR_BITS  ROM address
- mem_rdata  in  TYPE_BITS+NEXT_BITS+V  ROM data, valid 1 cycle after mem_rd. Fields: [type | next | vec].
- cam_we  in  1  type-table write
- cam_wr_addr  in  TYPE_BITS  table index
- cam_din  in  32  table data: [31] valid, [30:16] base (low ADDR_BITS used), [2:0] mult (low MULT_BITS used)
- cam_wr_ack  out  1  pulse one cycle after cam_we
- viol_count  out  CNT_BITS  saturating violation count
- pkt_count  out  CNT_BITS  saturating packet_done count

Behaviour:
- Reset:
  - All outputs 0.
  - Type table: all entries invalid, base 0, mult 0.
  - Node register 0. Counters 0.
  - FSM in ROOT.
- FSM states: ROOT, LOAD, RUN, FETCH, WAIT_SEQ, ACK2, REARM.
- ROOT: mem_rd=1, mem_addr=ROOT_ADDR. Go to LOAD.
- LOAD: capture mem_rdata into the node register. Go to RUN.
- FETCH: capture mem_rdata into the node register. Go to RUN.
- inst_ready = 1 only in RUN.
- RUN, new_inst_signal with hash h:
  - legal = monitor_en=0, OR (table[type].valid AND vec[h]).
  - Legal and monitor_en=1:
    - next cycle: mem_rd=1, mem_addr = (base + next*mult + popcount(vec[h-1:0])) mod 2**ADDR_BITS;
    - popcount for h=0 is 0;
    - state goes to FETCH.
    - Latency: acceptance edge T, read at T+1, node updated at end of T+2, inst_ready high at T+3.
  - monitor_en=0: no read; stay in RUN.
  - Illegal: at T+1 packet_drop_signal=1 for one cycle, out_ack_reset=1, viol_count+1, state goes to WAIT_SEQ.
- Overrun: new_inst_signal while inst_ready=0 in ROOT, LOAD or FETCH is a violation. It is handled identically to an illegal transition and aborts any pending fetch; the read data is ignored.
- Outside the check states (WAIT_SEQ, ACK2, REARM), new_inst_signal is ignored.
- packet_done in RUN or FETCH: pkt_count+1, out_ack_reset=1, state goes to WAIT_SEQ. No drop pulse.
- Simultaneous packet_done and violation: violation path taken (drop pulse, viol_count+1) and pkt_count+1.
- packet_done in WAIT_SEQ, ACK2, REARM, ROOT or LOAD: counted only.
- WAIT_SEQ: out_ack_reset held 1 while processor_reset_seq=1. On processor_reset_seq=0, go to ACK2.
- ACK2: out_ack_reset=1 for this one further cycle. Go to REARM.
- REARM: out_ack_reset=0. Wait for the first new_inst_signal, which is consumed and not checked. Then go to ROOT.
- Table write: on cam_we, the entry updates at the next edge and cam_wr_ack pulses the same edge. Writes are allowed in any state; a lookup in the same cycle sees the old entry.
- Counters saturate at 2**CNT_BITS-1.
- Reset asserted mid-operation: immediate return to reset values. No drop pulse is generated.

Test Plan:
1. Root and single step.
   - Setup: table[1] = {valid, base 0, mult 1}. ROM[0] = {type 1, next 5, vec 16'h0016}.
   - Stimulus: hash 4.
   - Expect: mem_rd with mem_addr 5+2=7 at T+1; inst_ready back at T+3; no drop.
2. Illegal hash.
   - Stimulus: same node, hash 0 (vec[0]=0).
   - Expect: packet_drop_signal one cycle at T+1; viol_count=1; out_ack_reset held until processor_reset_seq falls, plus 1 cycle; next instruction ignored; root re-read.
3. Overrun.
   - Stimulus: second new_inst_signal at T+1 after a legal step.
   - Expect: drop pulse, viol_count+1, pending read ignored.
4. packet_done during FETCH.
   - Expect: pkt_count+1, ack handshake, no drop, re-arm at ROOT_ADDR.
5. monitor_en=0.
   - Stimulus: 10 illegal hashes.
   - Expect: no drop, no mem_rd, counters unchanged. cam_we to entry 3 yields cam_wr_ack 1 cycle later.
6. Boundary arithmetic.
   - Setup: base 14'h3FFE, mult 2, next 1, hash 15 with vec 16'hFFFF.
   - Expect: address (3FFE+2+15) mod 2**14 = 14'h000F.
   - Also: viol_count saturates at FFFF.

Source files
------------

// File: rtl/dfa_monitor_param.sv
// rtl/dfa_monitor_param.sv - compressed-DFA instruction-flow monitor with node-type table and statistics
module dfa_monitor_param #(
    parameter int HASH_BITS = 4,
    parameter int NEXT_BITS = 12,
    parameter int TYPE_BITS = 4,
    parameter int ADDR_BITS = 14,
    parameter int MULT_BITS = 3,
    parameter int ROOT_ADDR = 0,
    parameter int CNT_BITS  = 16
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        monitor_en,
    input  logic                                        new_inst_signal,
    input  logic [HASH_BITS-1:0]                        four_bit_hash,
    output logic                                        inst_ready,
    input  logic                                        packet_done,
    input  logic                                        processor_reset_seq,
    output logic                                        packet_drop_signal,
    output logic                                        out_ack_reset,
    output logic                                        mem_rd,
    output logic [ADDR_BITS-1:0]                        mem_addr,
    input  logic [TYPE_BITS+NEXT_BITS+(2**HASH_BITS)-1:0] mem_rdata,
    input  logic                                        cam_we,
    input  logic [TYPE_BITS-1:0]                        cam_wr_addr,
    input  logic [31:0]                                 cam_din,
    output logic                                        cam_wr_ack,
    output logic [CNT_BITS-1:0]                         viol_count,
    output logic [CNT_BITS-1:0]                         pkt_count
);

    localparam int V         = 2 ** HASH_BITS;
    localparam int DEPTH     = 2 ** TYPE_BITS;
    localparam int PC_BITS   = HASH_BITS + 1;
    localparam int PROD_BITS = NEXT_BITS + MULT_BITS;
    localparam int SUM_BITS  = (PROD_BITS > ADDR_BITS) ? PROD_BITS : ADDR_BITS;
    localparam logic [V-1:0]        ONE_V   = {{(V-1){1'b0}}, 1'b1};
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_ROOT,
        S_LOAD,
        S_RUN,
        S_FETCH,
        S_WAIT_SEQ,
        S_ACK2,
        S_REARM
    } state_t;

    state_t                          state_q, state_d;
    logic [TYPE_BITS-1:0]            node_type_q, node_type_d;
    logic [NEXT_BITS-1:0]            node_next_q, node_next_d;
    logic [V-1:0]                    node_vec_q, node_vec_d;
    logic                            mem_rd_q, mem_rd_d;
    logic [ADDR_BITS-1:0]            mem_addr_q, mem_addr_d;
    logic                            rd_pend_q, rd_pend_d;
    logic                            drop_q, drop_d;
    logic                            cam_ack_q, cam_ack_d;
    logic [CNT_BITS-1:0]             viol_q, viol_d;
    logic [CNT_BITS-1:0]             pkt_q, pkt_d;
    logic [DEPTH-1:0]                tbl_valid_q, tbl_valid_d;
    logic [DEPTH-1:0][ADDR_BITS-1:0] tbl_base_q, tbl_base_d;
    logic [DEPTH-1:0][MULT_BITS-1:0] tbl_mult_q, tbl_mult_d;

    logic                 cur_valid;
    logic [ADDR_BITS-1:0] cur_base;
    logic [MULT_BITS-1:0] cur_mult;
    logic [V-1:0]         below_mask;
    logic [PC_BITS-1:0]   rank;
    logic [PROD_BITS-1:0] stride;
    logic [SUM_BITS-1:0]  step_sum;
    logic [ADDR_BITS-1:0] step_addr;
    logic                 legal;
    logic                 viol_hit;
    logic                 done_hit;
    logic                 cam_din_unused;

    assign cam_din_unused = ^cam_din;

    // Legality and child address of the current node for the presented hash
    always_comb begin
        cur_valid  = tbl_valid_q[node_type_q];
        cur_base   = tbl_base_q[node_type_q];
        cur_mult   = tbl_mult_q[node_type_q];
        below_mask = (ONE_V << four_bit_hash) - ONE_V;
        rank       = '0;
        for (int i = 0; i < V; i++) begin
            rank = rank + PC_BITS'(node_vec_q[i] & below_mask[i]);
        end
        stride    = PROD_BITS'(node_next_q) * PROD_BITS'(cur_mult);
        step_sum  = SUM_BITS'(cur_base) + SUM_BITS'(stride) + SUM_BITS'(rank);
        step_addr = step_sum[ADDR_BITS-1:0];
        legal     = cur_valid & node_vec_q[four_bit_hash];
    end

    // Type-table update; a lookup this cycle still sees the old entry
    always_comb begin
        tbl_valid_d = tbl_valid_q;
        tbl_base_d  = tbl_base_q;
        tbl_mult_d  = tbl_mult_q;
        cam_ack_d   = cam_we;
        if (cam_we) begin
            tbl_valid_d[cam_wr_addr] = cam_din[31];
            tbl_base_d[cam_wr_addr]  = cam_din[16 +: ADDR_BITS];
            tbl_mult_d[cam_wr_addr]  = cam_din[0 +: MULT_BITS];
        end
    end

    // Walk state machine: ROM fetches, violation/packet handling, reset handshake, counters
    always_comb begin
        state_d     = state_q;
        node_type_d = node_type_q;
        node_next_d = node_next_q;
        node_vec_d  = node_vec_q;
        mem_rd_d    = 1'b0;
        mem_addr_d  = '0;
        rd_pend_d   = mem_rd_q;
        drop_d      = 1'b0;
        viol_d      = viol_q;
        pkt_d       = pkt_q;
        viol_hit    = 1'b0;
        done_hit    = 1'b0;

        case (state_q)
            S_ROOT: begin
                if (monitor_en && new_inst_signal) begin
                    viol_hit = 1'b1;
                end else begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = ADDR_BITS'(ROOT_ADDR);
                    state_d    = S_LOAD;
                end
            end
            S_LOAD, S_FETCH: begin
                // Read data arrives the cycle after the strobe, tracked by rd_pend_q
                if (monitor_en && new_inst_signal) begin
                    viol_hit = 1'b1;
                end else if (packet_done && (state_q == S_FETCH)) begin
                    done_hit = 1'b1;
                end else if (rd_pend_q) begin
                    node_type_d = mem_rdata[NEXT_BITS+V +: TYPE_BITS];
                    node_next_d = mem_rdata[V +: NEXT_BITS];
                    node_vec_d  = mem_rdata[0 +: V];
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                if (monitor_en && new_inst_signal && !legal) begin
                    viol_hit = 1'b1;
                end else if (packet_done) begin
                    done_hit = 1'b1;
                end else if (monitor_en && new_inst_signal) begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = step_addr;
                    state_d    = S_FETCH;
                end
            end
            S_WAIT_SEQ: begin
                if (!processor_reset_seq) begin
                    state_d = S_ACK2;
                end
            end
            S_ACK2: begin
                state_d = S_REARM;
            end
            S_REARM: begin
                if (new_inst_signal) begin
                    state_d = S_ROOT;
                end
            end
            default: begin
                state_d = S_ROOT;
            end
        endcase

        if (viol_hit || done_hit) begin
            state_d = S_WAIT_SEQ;
        end
        if (viol_hit) begin
            drop_d = 1'b1;
            viol_d = (viol_q == CNT_MAX) ? viol_q : viol_q + CNT_ONE;
        end
        if (packet_done) begin
            pkt_d = (pkt_q == CNT_MAX) ? pkt_q : pkt_q + CNT_ONE;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_ROOT;
            node_type_q <= '0;
            node_next_q <= '0;
            node_vec_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            rd_pend_q   <= 1'b0;
            drop_q      <= 1'b0;
            cam_ack_q   <= 1'b0;
            viol_q      <= '0;
            pkt_q       <= '0;
            tbl_valid_q <= '0;
            tbl_base_q  <= '0;
            tbl_mult_q  <= '0;
        end else begin
            state_q     <= state_d;
            node_type_q <= node_type_d;
            node_next_q <= node_next_d;
            node_vec_q  <= node_vec_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            rd_pend_q   <= rd_pend_d;
            drop_q      <= drop_d;
            cam_ack_q   <= cam_ack_d;
            viol_q      <= viol_d;
            pkt_q       <= pkt_d;
            tbl_valid_q <= tbl_valid_d;
            tbl_base_q  <= tbl_base_d;
            tbl_mult_q  <= tbl_mult_d;
        end
    end

    assign inst_ready         = (state_q == S_RUN);
    assign out_ack_reset      = (state_q == S_WAIT_SEQ) || (state_q == S_ACK2);
    assign packet_drop_signal = drop_q;
    assign mem_rd             = mem_rd_q;
    assign mem_addr           = mem_addr_q;
    assign cam_wr_ack         = cam_ack_q;
    assign viol_count         = viol_q;
    assign pkt_count          = pkt_q;

endmodule

// File: tb/tb_dfa_monitor_param.sv
// tb/tb_dfa_monitor_param.sv - self-checking bench for dfa_monitor_param against a DFA-walk reference model
module tb_dfa_monitor_param;

    localparam int AB   = 14;
    localparam int CB   = 4;
    localparam int CMAX = (1 << CB) - 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        monitor_en = 1'b1;
    logic        new_inst_signal = 1'b0;
    logic [3:0]  four_bit_hash = '0;
    logic        inst_ready;
    logic        packet_done = 1'b0;
    logic        processor_reset_seq = 1'b0;
    logic        packet_drop_signal;
    logic        out_ack_reset;
    logic        mem_rd;
    logic [13:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        cam_we = 1'b0;
    logic [3:0]  cam_wr_addr = '0;
    logic [31:0] cam_din = '0;
    logic        cam_wr_ack;
    logic [CB-1:0] viol_count;
    logic [CB-1:0] pkt_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] rom [0:(1<<AB)-1];
    bit          tv [16];
    int          tbase [16];
    int          tmult [16];
    logic [31:0] cur;
    int          exp_viol;
    int          exp_pkt;
    logic [13:0] seen_addr;

    dfa_monitor_param #(.CNT_BITS(CB)) dut (
        .clk(clk), .reset(reset), .monitor_en(monitor_en),
        .new_inst_signal(new_inst_signal), .four_bit_hash(four_bit_hash),
        .inst_ready(inst_ready), .packet_done(packet_done),
        .processor_reset_seq(processor_reset_seq),
        .packet_drop_signal(packet_drop_signal), .out_ack_reset(out_ack_reset),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .cam_we(cam_we), .cam_wr_addr(cam_wr_addr), .cam_din(cam_din),
        .cam_wr_ack(cam_wr_ack), .viol_count(viol_count), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    // synchronous ROM: data valid the cycle after the strobe
    always @(posedge clk) if (mem_rd) mem_rdata <= rom[mem_addr];

    function automatic logic [31:0] nw(input int t, input int nx, input int vec);
        return {4'(t), 12'(nx), 16'(vec)};
    endfunction

    function automatic int sat(input int c);
        return (c >= CMAX) ? CMAX : c + 1;
    endfunction

    function automatic bit is_legal(input logic [31:0] w, input int h);
        return tv[int'(w[31:28])] && w[h];
    endfunction

    function automatic int exp_addr(input logic [31:0] w, input int h);
        int t;
        int nx;
        logic [15:0] mask;
        t    = int'(w[31:28]);
        nx   = int'(w[27:16]);
        mask = 16'((32'd1 << h) - 1);
        return (tbase[t] + nx * tmult[t] + $countones(w[15:0] & mask)) % (1 << AB);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset;
        for (int i = 0; i < 16; i++) begin
            tv[i] = 1'b0; tbase[i] = 0; tmult[i] = 0;
        end
        exp_viol = 0;
        exp_pkt  = 0;
    endtask

    task automatic cam_write(input int idx, input bit v, input int base, input int mult);
        cam_we = 1'b1; cam_wr_addr = 4'(idx);
        cam_din = {v, 15'(base), 13'b0, 3'(mult)};
        tick;
        cam_we = 1'b0;
        chk("cam_wr_ack", cam_wr_ack, 1);
        tv[idx] = v; tbase[idx] = base % (1 << AB); tmult[idx] = mult % 8;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!inst_ready && n < 20) begin tick; n++; end
        chk(tag, inst_ready, 1);
    endtask

    // one checked instruction from RUN; viol reports whether the model expected a violation
    task automatic step(input int h, output bit viol);
        int a;
        viol = !is_legal(cur, h);
        a = exp_addr(cur, h);
        new_inst_signal = 1'b1; four_bit_hash = 4'(h);
        tick;
        new_inst_signal = 1'b0;
        seen_addr = mem_addr;
        if (!viol) begin
            chk("step_rd", mem_rd, 1);
            chk("step_addr", mem_addr, a);
            chk("step_nodrop", packet_drop_signal, 0);
            chk("step_busy", inst_ready, 0);
            tick; tick;
            chk("step_ready_t3", inst_ready, 1);
            cur = rom[a];
        end else begin
            chk("viol_drop", packet_drop_signal, 1);
            chk("viol_no_rd", mem_rd, 0);
            exp_viol = sat(exp_viol);
            chk("viol_count", viol_count, exp_viol);
        end
    endtask

    // entered in the first WAIT_SEQ cycle; leaves in REARM
    task automatic handshake(input int nseq, input bit pd);
        chk("ack_on", out_ack_reset, 1);
        packet_done = pd;
        processor_reset_seq = (nseq > 0);
        for (int i = 0; i < nseq; i++) begin
            tick;
            packet_done = 1'b0;
            chk("ack_hold", out_ack_reset, 1);
            chk("drop_single", packet_drop_signal, 0);
        end
        processor_reset_seq = 1'b0;
        tick;
        packet_done = 1'b0;
        chk("ack_extra", out_ack_reset, 1);
        chk("drop_single2", packet_drop_signal, 0);
        tick;
        chk("ack_off", out_ack_reset, 0);
        if (pd) exp_pkt = sat(exp_pkt);
        chk("pkt_count", pkt_count, exp_pkt);
    endtask

    // entered in REARM; overrun=1 holds the instruction into ROOT to force a violation
    task automatic rearm(input bit overrun);
        chk("rearm_not_ready", inst_ready, 0);
        new_inst_signal = 1'b1; four_bit_hash = 4'($urandom_range(0, 15));
        tick;
        if (overrun) begin
            tick;
            new_inst_signal = 1'b0;
            chk("root_overrun_drop", packet_drop_signal, 1);
            chk("root_overrun_rd", mem_rd, 0);
            exp_viol = sat(exp_viol);
            chk("root_overrun_cnt", viol_count, exp_viol);
        end else begin
            new_inst_signal = 1'b0;
            chk("rearm_nodrop", packet_drop_signal, 0);
            tick;
            chk("root_rd", mem_rd, 1);
            chk("root_addr", mem_addr, 0);
            wait_ready("root_ready");
            cur = rom[0];
        end
    endtask

    initial begin
        bit v;
        int h;
        model_reset();
        for (int i = 0; i < (1 << AB); i++) rom[i] = '0;
        rom[0] = nw(1, 5, 16'h0016);
        rom[7] = nw(1, 5, 16'h0016);

        // reset values
        tick; tick;
        chk("rst_ready", inst_ready, 0);
        chk("rst_drop", packet_drop_signal, 0);
        chk("rst_ack", out_ack_reset, 0);
        chk("rst_rd", mem_rd, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_camack", cam_wr_ack, 0);
        chk("rst_viol", viol_count, 0);
        chk("rst_pkt", pkt_count, 0);
        reset = 1'b0;
        cam_write(1, 1, 0, 1);
        wait_ready("boot_ready");
        cur = rom[0];

        // 1: single legal step, hash 4 -> address 7
        step(4, v);
        chk("t1_addr7", seen_addr, 7);

        // 2: illegal hash 0
        step(0, v);
        chk("t2_viol1", viol_count, 1);
        handshake(3, 1'b0);
        rearm(1'b0);

        // 3: overrun in FETCH
        new_inst_signal = 1'b1; four_bit_hash = 4'd4;
        tick;
        chk("t3_rd", mem_rd, 1);
        tick;
        new_inst_signal = 1'b0;
        chk("t3_drop", packet_drop_signal, 1);
        chk("t3_no_rd", mem_rd, 0);
        exp_viol = sat(exp_viol);
        chk("t3_viol", viol_count, exp_viol);
        handshake(2, 1'b0);
        rearm(1'b0);

        // 4: packet_done during FETCH
        new_inst_signal = 1'b1; four_bit_hash = 4'd4;
        tick;
        new_inst_signal = 1'b0; packet_done = 1'b1;
        chk("t4_rd", mem_rd, 1);
        tick;
        packet_done = 1'b0;
        exp_pkt = sat(exp_pkt);
        chk("t4_nodrop", packet_drop_signal, 0);
        chk("t4_ack", out_ack_reset, 1);
        chk("t4_pkt", pkt_count, exp_pkt);
        handshake(1, 1'b0);
        rearm(1'b0);

        // 5: monitoring disabled
        monitor_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            do h = $urandom_range(0, 15); while (is_legal(cur, h));
            new_inst_signal = 1'b1; four_bit_hash = 4'(h);
            tick;
            new_inst_signal = 1'b0;
            chk("t5_nodrop", packet_drop_signal, 0);
            chk("t5_no_rd", mem_rd, 0);
            chk("t5_ready", inst_ready, 1);
        end
        chk("t5_viol", viol_count, exp_viol);
        chk("t5_pkt", pkt_count, exp_pkt);
        cam_write(3, 1, 16'h0100, 3);
        tick;
        chk("t5_ack_pulse", cam_wr_ack, 0);
        monitor_en = 1'b1;

        // 6: address wrap and counter saturation
        cam_write(2, 1, 14'h3FFE, 2);
        rom[7]  = nw(2, 1, 16'hFFFF);
        rom[15] = nw(1, 5, 16'h0016);
        step(4, v);
        step(15, v);
        chk("t6_wrap_addr", seen_addr, 14'h000F);
        step(0, v);
        handshake(0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            rearm(1'b1);
            handshake(0, 1'b1);
        end
        rearm(1'b0);
        chk("t6_viol_sat", viol_count, CMAX);
        chk("t6_pkt_sat", pkt_count, CMAX);

        // randomized walk over a random DFA image
        for (int t = 0; t < 4; t++) cam_write(t, 1, $urandom_range(0, 16383), $urandom_range(0, 7));
        cam_write(4, 0, 0, 0);
        for (int i = 0; i < (1 << AB); i++) rom[i] = {4'($urandom_range(0, 4)), 12'($urandom), 16'($urandom)};
        for (int i = 0; i < 80; i++) begin
            step($urandom_range(0, 15), v);
            if (v) begin
                handshake($urandom_range(0, 2), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) begin
                    rearm(1'b1);
                    handshake(0, 1'b0);
                end
                rearm(1'b0);
            end
        end

        // reset mid-fetch: no drop, everything cleared, table invalid afterwards
        new_inst_signal = 1'b1; four_bit_hash = 4'($urandom_range(0, 15));
        tick;
        new_inst_signal = 1'b0; reset = 1'b1;
        tick;
        chk("mid_rst_drop", packet_drop_signal, 0);
        chk("mid_rst_ack", out_ack_reset, 0);
        chk("mid_rst_rd", mem_rd, 0);
        chk("mid_rst_viol", viol_count, 0);
        chk("mid_rst_pkt", pkt_count, 0);
        reset = 1'b0;
        model_reset();
        wait_ready("mid_rst_ready");
        cur = rom[0];
        step($urandom_range(0, 15), v);
        chk("tbl_cleared_viol", viol_count, 1);
        handshake(0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
